// File: rtl/embedded_io_bank.sv
// ---------------------------------------------------------------------------
// embedded_io_bank
//
// Multi-channel IO bank between SoC pads and eFPGA fabric IO. Each channel
// has a 2-bit runtime mode:
//   00 bypass            : everything combinational (legacy single-pad cell)
//   01 registered input  : SOC_IN -> FPGA_IN through a SYNC_STAGES synchroniser
//   10 registered output : SOC_OUT / SOC_DIR registered, with OE turnaround
//   11 both registered
// GLOBAL_EN=0 forces all pads into a safe input state (no drive, zero data).
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   GLOBAL_EN           1 = operational, 0 = safe state
//   CFG_WE/ADDR/MODE    per-channel mode write; out-of-range addresses ignored
//   SOC_IN              pad input data
//   SOC_OUT, SOC_DIR    pad output data and direction (1 = drive)
//   FPGA_IN             data to fabric
//   FPGA_OUT, FPGA_DIR  data and direction request from fabric
// ---------------------------------------------------------------------------
module embedded_io_bank #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2,
  localparam int AW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              GLOBAL_EN,
  input  logic              CFG_WE,
  input  logic [AW-1:0]     CFG_ADDR,
  input  logic [1:0]        CFG_MODE,
  input  logic [NUM_CH-1:0] SOC_IN,
  output logic [NUM_CH-1:0] SOC_OUT,
  output logic [NUM_CH-1:0] SOC_DIR,
  output logic [NUM_CH-1:0] FPGA_IN,
  input  logic [NUM_CH-1:0] FPGA_OUT,
  input  logic [NUM_CH-1:0] FPGA_DIR
);

  localparam logic [3:0] TA_LOAD = 4'(TURNAROUND);

  // mode[i][0] selects the registered input path, mode[i][1] the registered
  // output/direction path.
  logic [1:0]        mode   [NUM_CH];
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] dir_q;
  logic [3:0]        ta_cnt [NUM_CH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i]   <= 2'b00;
        ta_cnt[i] <= 4'd0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      out_q <= '0;
      dir_q <= '0;
    end else begin
      // Decoding by equality against every channel index means addresses
      // >= NUM_CH simply match nothing.
      for (int i = 0; i < NUM_CH; i++) begin
        if (CFG_WE && (CFG_ADDR == AW'(i))) begin
          mode[i] <= CFG_MODE;
        end
      end

      // Datapath registers run in every mode so switching modes never
      // needs a flush; the first registered value is already-captured data.
      sync_q[0] <= SOC_IN;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      out_q <= FPGA_OUT;

      // Turnaround guard: a sampled 0 (or disabled bank) drops drive at once
      // and reloads the counter; drive is granted only once the counter has
      // drained, i.e. after TURNAROUND+1 consecutive sampled 1s.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!GLOBAL_EN || !FPGA_DIR[i]) begin
          ta_cnt[i] <= TA_LOAD;
          dir_q[i]  <= 1'b0;
        end else if (ta_cnt[i] != 4'd0) begin
          ta_cnt[i] <= ta_cnt[i] - 4'd1;
          dir_q[i]  <= 1'b0;
        end else begin
          dir_q[i]  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    FPGA_IN = '0;
    SOC_OUT = '0;
    SOC_DIR = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      FPGA_IN[i] = GLOBAL_EN & (mode[i][0] ? sync_q[SYNC_STAGES-1][i] : SOC_IN[i]);
      SOC_OUT[i] = GLOBAL_EN & (mode[i][1] ? out_q[i] : FPGA_OUT[i]);
      SOC_DIR[i] = GLOBAL_EN & (mode[i][1] ? dir_q[i] : FPGA_DIR[i]);
    end
  end

endmodule
